rng_word_collector: RTL and testbench

// - Consumer end of the TRNG bit stream. Accepts debiased bits from the corrector
//   (bit_in, qualified by the one-cycle bit_valid strobe) and packs them into WIDTH-bit words.
// - Double-buffered (shift reg + output reg): collection continues while a finished word

---
 rtl/rng_word_collector_if.sv | 21 ++
 rtl/rng_word_collector.sv | 155 +++++++++++++++
 tb/tb_rng_word_collector.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rng_word_collector_if.sv
// Word-side valid/ready port of the RNG word collector.
// master: drives word_out/word_valid, samples word_ready; slave: the reverse.
interface rng_word_collector_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output word_out,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/rng_word_collector.sv
// Packs debiased TRNG bits LSB-first into WIDTH-bit words, double-buffered.
// Ports: clk, rst (async high), bit_in/bit_valid in, wo (word valid/ready
// master), drop_cnt (saturating lost-bit count), health_fail (sticky).
// Optional repetition-count health test: define RNG_HEALTH_TEST_EN.
module rng_word_collector #(
  parameter int WIDTH     = 32,
  parameter int DROP_W    = 8,
  parameter int RCT_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  rng_word_collector_if.master wo,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic                 health_fail
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    FILL,
    FULL
  } state_t;

  // Assert asynchronously, release two clocks after rst drops.
  logic [1:0] rst_sync_q;
  logic       irst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign irst = rst_sync_q[1];

  state_t            state_q;
  logic [WIDTH-1:0]  shift_q;
  logic [WIDTH-1:0]  word_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              valid_q;
  logic [DROP_W-1:0] drop_q;

  logic             xfer;
  logic             accept;
  logic             last_bit;
  logic             discard;
  logic [WIDTH-1:0] full_word;

  assign xfer      = valid_q & wo.word_ready;
  assign accept    = bit_valid & (state_q == FILL);
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  // Right shift: after WIDTH bits the first one sits at bit 0.
  assign full_word = {bit_in, shift_q[WIDTH-1:1]};

`ifdef RNG_HEALTH_TEST_EN
  localparam int RUN_W = $clog2(RCT_LIMIT + 1);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic             last_q;
  logic             hf_q;
  logic             rct_hit;

  always_comb begin
    run_d = run_q;
    if (accept) begin
      if (run_q == '0 || bit_in != last_q) begin
        run_d = RUN_W'(1);
      end else if (run_q != RUN_W'(RCT_LIMIT)) begin
        run_d = run_q + 1'b1;
      end
    end
  end

  assign rct_hit = accept && (run_d == RUN_W'(RCT_LIMIT));

  always_ff @(posedge clk or posedge irst) begin
    if (irst) begin
      run_q  <= '0;
      last_q <= 1'b0;
      hf_q   <= 1'b0;
    end else begin
      run_q <= run_d;
      if (accept) begin
        last_q <= bit_in;
      end
      if (rct_hit) begin
        hf_q <= 1'b1;
      end
    end
  end

  // A word finishing on the failing bit is already suspect: drop it too.
  assign discard     = hf_q | rct_hit;
  assign health_fail = hf_q;
`else
  assign discard     = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge clk or posedge irst) begin
    if (irst) begin
      state_q <= FILL;
      shift_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (xfer) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        FILL: begin
          if (bit_valid) begin
            shift_q <= full_word;
            if (last_bit) begin
              cnt_q <= '0;
              if (!discard) begin
                if (!valid_q || xfer) begin
                  word_q  <= full_word;
                  valid_q <= 1'b1;
                end else begin
                  state_q <= FULL;
                end
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (bit_valid && drop_q != '1) begin
            drop_q <= drop_q + 1'b1;
          end
          if (xfer) begin
            word_q  <= shift_q;
            valid_q <= 1'b1;
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign wo.word_out   = word_q;
  assign wo.word_valid = valid_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_rng_word_collector.sv
// Self-checking bench for rng_word_collector: directed steps plus random
// traffic compared every cycle against a word/queue-level reference model.
module tb_rng_word_collector;

  localparam int W   = 32;
  localparam int DW  = 8;
  localparam int RCT = 16;
`ifdef RNG_HEALTH_TEST_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic [DW-1:0] drop_cnt;
  logic          health_fail;

  rng_word_collector_if #(.WIDTH(W)) wif ();

  rng_word_collector #(
    .WIDTH(W),
    .DROP_W(DW),
    .RCT_LIMIT(RCT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bit_in(bit_in),
    .bit_valid(bit_valid),
    .wo(wif),
    .drop_cnt(drop_cnt),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a bit list being collected, one output slot and
  // one parked word, plus the run-length health check.
  bit [W-1:0] m_acc;
  bit [W-1:0] m_out;
  bit [W-1:0] m_held;
  int         m_k;
  bit         m_valid;
  bit         m_full;
  int         m_drop;
  bit         m_hf;
  int         m_run;
  bit         m_last;

  function automatic void m_reset();
    m_acc = '0; m_out = '0; m_held = '0;
    m_k = 0; m_valid = 0; m_full = 0;
    m_drop = 0; m_hf = 0; m_run = 0; m_last = 0;
  endfunction

  function automatic void m_step(bit bv, bit b, bit rdy);
    bit xfer  = m_valid && rdy;
    bit full0 = m_full;
    bit hf0   = m_hf;
    bit hit   = 0;
    if (xfer) m_valid = 0;
    if (full0) begin
      if (bv && m_drop < DMAX) m_drop++;
      if (xfer) begin
        m_out = m_held; m_valid = 1; m_full = 0;
      end
    end else if (bv) begin
      if (HEALTH) begin
        m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
        m_last = b;
        hit    = (m_run >= RCT);
      end
      m_acc[m_k] = b;
      m_k++;
      if (m_k == W) begin
        m_k = 0;
        if (!(hf0 || hit)) begin
          if (!m_valid) begin
            m_out = m_acc; m_valid = 1;
          end else begin
            m_held = m_acc; m_full = 1;
          end
        end
      end
    end
    if (hit) m_hf = 1;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("word_valid", wif.word_valid, m_valid);
    chk("word_out", wif.word_out, m_out);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("health_fail", health_fail, m_hf);
  endtask

  task automatic step(input bit bv, input bit b, input bit rdy);
    bit_valid = bv;
    bit_in = b;
    wif.word_ready = rdy;
    @(posedge clk);
    m_step(bv, b, rdy);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    bit_valid = 0;
    wif.word_ready = 0;
    rst = 1;
    #1;
    chk("rst_valid", wif.word_valid, 0);
    chk("rst_word", wif.word_out, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_hf", health_fail, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  bit [W-1:0] exp_b;
  bit         rb;
  int         p;

  initial begin
    wif.word_ready = 0;
    #2;
    do_reset();

    // 1: alternating bits, ready high
    for (int k = 0; k < W; k++) step(1, (k % 2) == 0, 1);
    chk("t1_valid", wif.word_valid, 1);
    chk("t1_word", wif.word_out, 32'h5555_5555);
    step(0, 0, 1);
    chk("t1_low", wif.word_valid, 0);

    // 2: two buffered words, then drops
    for (int k = 0; k < W; k++) step(1, (k % 4) < 2, 0);
    chk("t2_word1", wif.word_out, 32'h3333_3333);
    for (int k = 0; k < W; k++) step(1, (k % 2) == 0, 0);
    for (int k = 0; k < 3; k++) step(1, 1, 0);
    chk("t2_drop", drop_cnt, 3);
    chk("t2_hold", wif.word_out, 32'h3333_3333);
    step(0, 0, 1);
    chk("t2_word2", wif.word_out, 32'h5555_5555);
    chk("t2_valid2", wif.word_valid, 1);
    step(0, 0, 1);
    chk("t2_empty", wif.word_valid, 0);
    chk("t2_drop_kept", drop_cnt, 3);

    // 3: saturation of drop counter
    for (int k = 0; k < 2 * W; k++) step(1, (k % 2) == 0, 0);
    for (int k = 0; k < 300; k++) step(1, k[0], 0);
    chk("t3_sat", drop_cnt, DMAX);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("t3_drained", wif.word_valid, 0);

    // 4: reset in the middle of a word
    for (int k = 0; k < 10; k++) step(1, 1, 0);
    do_reset();
    for (int k = 0; k < W; k++) step(1, (k % 2) == 0, 0);
    chk("t4_word", wif.word_out, 32'h5555_5555);
    chk("t4_valid", wif.word_valid, 1);
    step(0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 1);
    chk("t4_once", wif.word_valid, 0);

    // 5: transfer in the same cycle as the completing bit
    for (int k = 0; k < W; k++) step(1, 1'($urandom_range(0, 1)), 0);
    for (int k = 0; k < W; k++) begin
      rb = 1'($urandom_range(0, 1));
      exp_b[k] = rb;
      step(1, rb, k == W - 1);
      chk("t5_valid_high", wif.word_valid, 1);
    end
    chk("t5_word", wif.word_out, exp_b);
    step(0, 0, 1);
    chk("t5_drained", wif.word_valid, 0);

    // random traffic
    for (int ph = 0; ph < 6; ph++) begin
      p = (ph * 20) + 5;
      for (int c = 0; c < 500; c++) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) < p);
      end
    end

`ifdef RNG_HEALTH_TEST_EN
    // 6: repetition-count test
    do_reset();
    for (int k = 0; k < 15; k++) step(1, 1, 1);
    step(1, 0, 1);
    chk("t6_pass", health_fail, 0);
    for (int k = 0; k < RCT; k++) step(1, 1, 1);
    chk("t6_fail", health_fail, 1);
    chk("t6_no_word", wif.word_valid, 0);
    for (int k = 0; k < 2 * W; k++) step(1, (k % 2) == 0, 1);
    chk("t6_sticky", health_fail, 1);
    chk("t6_still_none", wif.word_valid, 0);
    do_reset();
    chk("t6_cleared", health_fail, 0);
`else
    chk("t6_tied", health_fail, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
